writeback_retire_stage: RTL

Registered, parametrised write-back/retire stage sitting between the memory stage and the register file/fetch redirect.
- Captures one retiring instruction per cycle under a valid/ready handshake.
- Selects memory or execute data and suppresses writes to register 0.
- Issues return redirects, counts retired instructions, and latches halt into a terminal state.
- Adds what the combinational write-back path lacks: pipelining, flush, halt FSM, retire counting and optional load alignment.

---
 rtl/writeback_retire_stage.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/writeback_retire_stage.sv
// Registered write-back/retire stage: selects load or execute data, drops r0 writes,
// issues return redirects, counts retirements and latches halt. Load alignment under WB_LOAD_ALIGN_EN.
module writeback_retire_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              iValid,
  output logic              oReady,
  input  logic              iFlush,
  input  logic [DATA_W-1:0] iMemData,
  input  logic [DATA_W-1:0] iExuData,
  input  logic [ADDR_W-1:0] iWriteAddr,
  input  logic              iWriteEn,
  input  logic              iMemToReg,
  input  logic [1:0]        iMemSize,
  input  logic              iMemSigned,
  input  logic [1:0]        iByteOff,
  input  logic              iRetCmd,
  input  logic [PC_W-1:0]   iRetAddr,
  input  logic              iHalt,
  output logic [DATA_W-1:0] oWriteData,
  output logic [ADDR_W-1:0] oWriteAddr,
  output logic              oWriteEn,
  output logic              oRetCmd,
  output logic [PC_W-1:0]   oRetAddr,
  output logic              oHalted,
  output logic [CNT_W-1:0]  oRetireCnt
);

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_HALTED = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic              we_q, we_d;
  logic              ret_q, ret_d;
  logic [PC_W-1:0]   retaddr_q, retaddr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              accept_c;
  logic [DATA_W-1:0] mem_aligned_c;

`ifdef WB_LOAD_ALIGN_EN
  logic [31:0] mem_lo_c;
  logic [7:0]  byte_c;
  logic [15:0] half_c;

  // Little-endian lane pick, then sign/zero fill up to DATA_W
  always_comb begin
    mem_lo_c      = iMemData[31:0];
    byte_c        = mem_lo_c[{iByteOff, 3'b000} +: 8];
    half_c        = mem_lo_c[{iByteOff[1], 4'b0000} +: 16];
    mem_aligned_c = iMemData;
    case (iMemSize)
      2'b00: begin
        mem_aligned_c       = {DATA_W{iMemSigned & byte_c[7]}};
        mem_aligned_c[7:0]  = byte_c;
      end
      2'b01: begin
        mem_aligned_c       = {DATA_W{iMemSigned & half_c[15]}};
        mem_aligned_c[15:0] = half_c;
      end
      2'b10: begin
        mem_aligned_c       = {DATA_W{iMemSigned & mem_lo_c[31]}};
        mem_aligned_c[31:0] = mem_lo_c;
      end
      default: mem_aligned_c = iMemData;
    endcase
  end
`else
  logic unused_align_c;

  assign mem_aligned_c  = iMemData;
  assign unused_align_c = ^{iMemSize, iMemSigned, iByteOff};
`endif

  assign accept_c = iValid & oReady & ~iFlush;

  // Next-state and capture logic; strobes default low so they last one cycle
  always_comb begin
    state_d   = state_q;
    wdata_d   = wdata_q;
    waddr_d   = waddr_q;
    we_d      = 1'b0;
    ret_d     = 1'b0;
    retaddr_d = retaddr_q;
    cnt_d     = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (accept_c) begin
          we_d  = iWriteEn & (iWriteAddr != '0);
          ret_d = iRetCmd;
          cnt_d = cnt_q + CNT_W'(1);
          if (we_d) begin
            wdata_d = iMemToReg ? mem_aligned_c : iExuData;
            waddr_d = iWriteAddr;
          end
          if (iRetCmd) retaddr_d = iRetAddr;
          if (iHalt) state_d = ST_HALTED;
        end
      end
      default: state_d = ST_HALTED;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q   <= ST_RUN;
      wdata_q   <= '0;
      waddr_q   <= '0;
      we_q      <= 1'b0;
      ret_q     <= 1'b0;
      retaddr_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      wdata_q   <= wdata_d;
      waddr_q   <= waddr_d;
      we_q      <= we_d;
      ret_q     <= ret_d;
      retaddr_q <= retaddr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign oReady     = (state_q == ST_RUN);
  assign oHalted    = (state_q == ST_HALTED);
  assign oWriteData = wdata_q;
  assign oWriteAddr = waddr_q;
  assign oWriteEn   = we_q;
  assign oRetCmd    = ret_q;
  assign oRetAddr   = retaddr_q;
  assign oRetireCnt = cnt_q;

endmodule
